// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and lane helpers for the data-memory controller
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Sub-word offsets below the access size are ignored, so misaligned halves force-align.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B:    be_gen = 4'b0001 << off;
      F3_H:    be_gen = 4'b0011 << {off[1], 1'b0};
      F3_W:    be_gen = 4'b1111;
      default: be_gen = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] funct3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_ext = {{24{b[7]}}, b};
      F3_BU:   load_ext = {24'b0, b};
      F3_H:    load_ext = {{16{h[15]}}, h};
      F3_HU:   load_ext = {16'b0, h};
      F3_W:    load_ext = word;
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port byte-writable RAM with registered read (old data on collision)
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[idx];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RISC-V load/store controller for on-chip data RAM
// Optional: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int               DEPTH_WORDS = 1024,
  parameter int               ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int              IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(DEPTH_WORDS) << 2;

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic        load_q, load_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic [ADDR_W-1:0] rel;
  logic              in_range, legal, misalign, fault, accept;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata, ram_rdata;

  // BASE_ADDR is word-aligned, so rel[1:0] equals req_addr[1:0].
  assign rel      = req_addr - BASE_ADDR;
  assign in_range = (req_addr >= BASE_ADDR) && ({1'b0, rel} < SPAN);

  always_comb begin
    case (req_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~req_we;
      default:          legal = 1'b0;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && rel[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (rel[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault     = ~in_range | ~legal | misalign;
  assign rsp_valid = (state_q == RESP);
  assign req_ready = (state_q == IDLE) | (rsp_valid & rsp_ready);
  assign accept    = req_valid & req_ready;
  assign ram_we    = (accept && req_we && !fault) ? be_gen(req_funct3, rel[1:0]) : 4'b0000;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   ram_wdata = {4{req_wdata[7:0]}};
      2'b01:   ram_wdata = {2{req_wdata[15:0]}};
      default: ram_wdata = req_wdata;
    endcase
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .en    (accept),
    .we    (ram_we),
    .idx   (rel[IDX_W+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    load_d  = load_q;
    f3_d    = f3_q;
    off_d   = off_q;
    if (accept) begin
      state_d = RESP;
      err_d   = fault;
      load_d  = ~req_we;
      f3_d    = req_funct3;
      off_d   = rel[1:0];
    end else if (rsp_valid && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      load_q  <= load_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  // RAM output only changes on accept, so the extracted data is stable while stalled.
  assign rsp_err   = err_q;
  assign rsp_rdata = (load_q && !err_q) ? load_ext(ram_rdata, f3_q, off_q) : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl against a byte-array memory model
module tb_dmem_ctrl;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;

  int tests = 0;
  int fails = 0;
  logic [7:0] mem_m [DEPTH*4];

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // Reference: memory as a flat byte array, accesses described by size and alignment.
  task automatic model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    logic [31:0] off, v;
    int size, a;
    bit bad;
    off  = addr - BASE;
    size = 1 << f3[1:0];
    bad  = (addr < BASE) || (off >= DEPTH*4);
    if (we) bad = bad || (f3 > 3'd2);
    else    bad = bad || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (int'(off[1:0]) % size != 0) bad = 1'b1;
`endif
    rd = 32'h0;
    er = bad;
    if (!bad) begin
      a = int'(off) & ~(size - 1);
      if (we) begin
        for (int i = 0; i < size; i++) mem_m[a+i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | ({24'h0, mem_m[a+i]} << (8*i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v - (32'd1 << (8*size));
        rd = v;
      end
    end
  endtask

  // Single transaction: returns whether the response appeared exactly one cycle after accept.
  task automatic do_xact(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output logic vld);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    vld = rsp_valid; rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: valid=%b rdata=%h err=%b ready=%b, want 0/0/0/1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [31:0] rd, er_rd; logic er, vld, mer;
    for (int w = 0; w < DEPTH; w++) begin
      model(1'b1, BASE + 32'(w*4), 3'b010, $urandom, er_rd, mer);
      do_xact(1'b1, BASE + 32'(w*4), 3'b010, {mem_m[w*4+3], mem_m[w*4+2], mem_m[w*4+1], mem_m[w*4]},
              rd, er, vld);
      tests++;
      if (vld !== 1'b1 || rd !== 32'h0 || er !== 1'b0) begin
        fails++;
        $display("FAIL fill_sw w%0d: valid=%b rdata=%h err=%b, want 1/0/0", w, vld, rd, er);
      end
    end
  endtask

  task automatic test_directed();
    logic        t_we [10] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    logic [7:0]  t_off[10] = '{8'h10, 8'h10, 8'h13, 8'h13, 8'h13, 8'h12, 8'h16, 8'h16, 8'h16, 8'h14};
    logic [2:0]  t_f3 [10] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd4, 3'd0, 3'd1, 3'd1, 3'd5, 3'd2};
    logic [31:0] t_wd [10] = '{32'hDEADBEEF, 0, 32'h80, 0, 0, 0, 32'h8001, 0, 0, 0};
    logic [31:0] t_exp[10] = '{0, 32'hDEADBEEF, 0, 32'hFFFFFF80, 32'h80, 32'hFFFFFFAD, 0,
                               32'hFFFF8001, 32'h00008001, 0};
    logic [31:0] rd, mrd; logic er, vld, mer;
    for (int i = 0; i < 10; i++) begin
      model(t_we[i], BASE + 32'(t_off[i]), t_f3[i], t_wd[i], mrd, mer);
      do_xact(t_we[i], BASE + 32'(t_off[i]), t_f3[i], t_wd[i], rd, er, vld);
      if (i == 9) begin
        tests++;
        if (vld !== 1'b1 || rd !== mrd || er !== 1'b0 || rd[31:16] !== 16'h8001) begin
          fails++;
          $display("FAIL directed lw_after_sh: valid=%b rdata=%h err=%b, want 1/%h/0", vld, rd, er, mrd);
        end
      end else begin
        tests++;
        if (vld !== 1'b1 || rd !== t_exp[i] || er !== 1'b0) begin
          fails++;
          $display("FAIL directed step%0d: valid=%b rdata=%h err=%b, want 1/%h/0", i, vld, rd, er, t_exp[i]);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic        t_we [5] = '{0, 0, 0, 1, 0};
    logic [31:0] t_ad [5] = '{BASE + DEPTH*4, BASE - 4, BASE + 32'h20, BASE + 32'h20, BASE + 32'h20};
    logic [2:0]  t_f3 [5] = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd2};
    logic        t_err[5] = '{1, 1, 1, 1, 0};
    logic [31:0] rd, mrd; logic er, vld, mer;
    for (int i = 0; i < 5; i++) begin
      model(t_we[i], t_ad[i], t_f3[i], 32'h1234_5678, mrd, mer);
      do_xact(t_we[i], t_ad[i], t_f3[i], 32'h1234_5678, rd, er, vld);
      tests++;
      if (vld !== 1'b1 || er !== t_err[i] || rd !== (t_err[i] ? 32'h0 : mrd)) begin
        fails++;
        $display("FAIL errors step%0d: valid=%b rdata=%h err=%b, want 1/%h/%b",
                 i, vld, rd, er, t_err[i] ? 32'h0 : mrd, t_err[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic        t_we [4] = '{0, 0, 1, 0};
    logic [7:0]  t_off[4] = '{8'h11, 8'h17, 8'h19, 8'h18};
    logic [2:0]  t_f3 [4] = '{3'd2, 3'd1, 3'd2, 3'd2};
    logic [31:0] rd, mrd; logic er, vld, mer;
    for (int i = 0; i < 4; i++) begin
      model(t_we[i], BASE + 32'(t_off[i]), t_f3[i], 32'hA5C3_0F96, mrd, mer);
      do_xact(t_we[i], BASE + 32'(t_off[i]), t_f3[i], 32'hA5C3_0F96, rd, er, vld);
      tests++;
      if (vld !== 1'b1 || rd !== mrd || er !== mer) begin
        fails++;
        $display("FAIL misalign step%0d: valid=%b rdata=%h err=%b, want 1/%h/%b", i, vld, rd, er, mrd, mer);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 16;
    logic [31:0] e_rd [N]; logic e_er [N];
    rsp_ready = 1'b1;
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e_rd[i-1] || rsp_err !== e_er[i-1] || req_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b beat%0d: valid=%b rdata=%h err=%b ready=%b, want 1/%h/%b/1",
                   i-1, rsp_valid, rsp_rdata, rsp_err, req_ready, e_rd[i-1], e_er[i-1]);
        end
      end
      if (i < N) begin
        req_valid = 1'b1; req_we = 1'($urandom_range(0, 1));
        req_addr = BASE + 32'($urandom_range(0, DEPTH*4 - 1));
        req_funct3 = 3'($urandom_range(0, 5)); req_wdata = $urandom;
        model(req_we, req_addr, req_funct3, req_wdata, e_rd[i], e_er[i]);
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ea, eb; logic ma, mb;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 32'h2C; req_funct3 = 3'd2; rsp_ready = 1'b0;
    model(1'b0, req_addr, 3'd2, 32'h0, ea, ma);
    @(negedge clk);
    req_addr = BASE + 32'h31; req_funct3 = 3'd0;
    model(1'b0, req_addr, 3'd0, 32'h0, eb, mb);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== ea || rsp_err !== 1'b0) begin
        fails++;
        $display("FAIL stall cyc%0d: ready=%b valid=%b rdata=%h err=%b, want 0/1/%h/0",
                 k, req_ready, rsp_valid, rsp_rdata, rsp_err, ea);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: ready=%b, want 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== eb || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL stall_next: valid=%b rdata=%h err=%b, want 1/%h/0", rsp_valid, rsp_rdata, rsp_err, eb);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rd, mrd; logic [2:0] f3; logic we, er, vld, mer;
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       addr = BASE + DEPTH*4 + 32'($urandom_range(0, 64));
        1:       addr = BASE - 32'($urandom_range(1, 64));
        default: addr = BASE + 32'($urandom_range(0, DEPTH*4 - 1));
      endcase
      model(we, addr, f3, wd, mrd, mer);
      do_xact(we, addr, f3, wd, rd, er, vld);
      tests++;
      if (vld !== 1'b1 || rd !== mrd || er !== mer) begin
        fails++;
        $display("FAIL random%0d we=%b f3=%0d addr=%h: valid=%b rdata=%h err=%b, want 1/%h/%b",
                 i, we, f3, addr, vld, rd, er, mrd, mer);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, mrd, wd; logic er, vld, mer;
    wd = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h40; req_funct3 = 3'd2; req_wdata = wd;
    rsp_ready = 1'b0;
    model(1'b1, BASE + 32'h40, 3'd2, wd, mrd, mer);
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: valid=%b, want 1", rsp_valid);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_async: valid=%b err=%b rdata=%h, want 0/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model(1'b0, BASE + 32'h40, 3'd2, 32'h0, mrd, mer);
    do_xact(1'b0, BASE + 32'h40, 3'd2, 32'h0, rd, er, vld);
    tests++;
    if (vld !== 1'b1 || rd !== mrd || er !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_kept: valid=%b rdata=%h err=%b, want 1/%h/0", vld, rd, er, mrd);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_errors();
    test_misalign();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
